// File: rtl/cordic_pkg.sv
// Shared constants for the unified rotation/vectoring CORDIC pipeline.
// Angles are in hundredths of a degree.
package cordic_pkg;

   // 1/K for the micro-rotation gain, Q1.15
   localparam int GAIN_K    = 19898;
   localparam int ANGLE_90  = 9000;
   localparam int ANGLE_180 = 18000;

   localparam logic MODE_ROT = 1'b0;
   localparam logic MODE_VEC = 1'b1;

   // atan(2^-i) in hundredths of a degree
   function automatic int atan_lut(input int idx);
      case (idx)
         0:       return 4500;
         1:       return 2657;
         2:       return 1404;
         3:       return 713;
         4:       return 358;
         5:       return 179;
         6:       return 90;
         7:       return 45;
         8:       return 22;
         9:       return 11;
         10:      return 6;
         11:      return 3;
         12:      return 1;
         13:      return 1;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/cordic_stage.sv
// One CORDIC micro-rotation stage with its valid bit and mode tag.
module cordic_stage
   import cordic_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int IDX    = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     advance,
   input  logic                     src_valid,
   input  logic                     src_mode,
   input  logic signed [DATA_W+1:0] src_x,
   input  logic signed [DATA_W+1:0] src_y,
   input  logic signed [DATA_W:0]   src_z,
   output logic                     dst_valid,
   output logic                     dst_mode,
   output logic signed [DATA_W+1:0] dst_x,
   output logic signed [DATA_W+1:0] dst_y,
   output logic signed [DATA_W:0]   dst_z
);

   localparam int XW = DATA_W + 2;
   localparam int ZW = DATA_W + 1;
   localparam logic signed [ZW-1:0] ATAN_I = ZW'(atan_lut(IDX));

   logic                 neg;
   logic                 hold;
   logic signed [XW-1:0] x_sh, y_sh, x_nx, y_nx;
   logic signed [ZW-1:0] z_nx;

   // micro-rotation; a zero vector in vectoring mode is frozen so its angle stays 0
   always_comb begin
      x_sh = src_x >>> IDX;
      y_sh = src_y >>> IDX;
      hold = (src_mode == MODE_VEC) && (src_x == '0) && (src_y == '0);
      if (src_mode == MODE_VEC) neg = !src_y[XW-1];
      else                      neg = src_z[ZW-1];
      if (hold) begin
         x_nx = src_x;
         y_nx = src_y;
         z_nx = src_z;
      end else if (neg) begin
         x_nx = src_x + y_sh;
         y_nx = src_y - x_sh;
         z_nx = src_z + ATAN_I;
      end else begin
         x_nx = src_x - y_sh;
         y_nx = src_y + x_sh;
         z_nx = src_z - ATAN_I;
      end
   end

   // valid bit, cleared by reset, held on stall
   always_ff @(posedge clk) begin
      if (rst)          dst_valid <= 1'b0;
      else if (advance) dst_valid <= src_valid;
   end

   // data and mode tag, held on stall
   always_ff @(posedge clk) begin
      if (advance) begin
         dst_mode <= src_mode;
         dst_x    <= x_nx;
         dst_y    <= y_nx;
         dst_z    <= z_nx;
      end
   end

endmodule

// File: rtl/cordic_unified_pipe.sv
// Unified rotation/vectoring CORDIC: pre-rotation stage, ITER micro-rotation
// stages, gain/saturation output stage. One global stall from out_ready.
module cordic_unified_pipe
   import cordic_pkg::*;
#(
   parameter int DATA_W    = 16,
   parameter int ITER      = 14,
   parameter int GAIN_COMP = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     mode_in,
   input  logic signed [DATA_W-1:0] x_in,
   input  logic signed [DATA_W-1:0] y_in,
   input  logic signed [DATA_W-1:0] angle_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     mode_out,
   output logic signed [DATA_W-1:0] x_out,
   output logic signed [DATA_W-1:0] y_out,
   output logic signed [DATA_W-1:0] angle_out
);

   localparam int XW = DATA_W + 2;
   localparam int ZW = DATA_W + 1;
   localparam int PW = XW + 16;
   localparam logic signed [ZW-1:0] Z90    = ZW'(ANGLE_90);
   localparam logic signed [ZW-1:0] Z180   = ZW'(ANGLE_180);
   localparam logic signed [XW-1:0] SAT_HI = XW'((2 ** (DATA_W - 1)) - 1);
   localparam logic signed [XW-1:0] SAT_LO = XW'(-(2 ** (DATA_W - 1)));

   logic                 advance;
   logic signed [XW-1:0] xe, ye, pre_x, pre_y;
   logic signed [ZW-1:0] ze, pre_z;

   logic                 s_valid [ITER+1];
   logic                 s_mode  [ITER+1];
   logic signed [XW-1:0] s_x     [ITER+1];
   logic signed [XW-1:0] s_y     [ITER+1];
   logic signed [ZW-1:0] s_z     [ITER+1];

   logic                 pre_valid_q, pre_mode_q;
   logic signed [XW-1:0] pre_x_q, pre_y_q;
   logic signed [ZW-1:0] pre_z_q;

   logic signed [PW-1:0] x_prod, y_prod;
   logic signed [XW-1:0] x_fin, y_fin;

   function automatic logic signed [DATA_W-1:0] sat(input logic signed [XW-1:0] v);
      if (v > SAT_HI) return DATA_W'(SAT_HI);
      if (v < SAT_LO) return DATA_W'(SAT_LO);
      return DATA_W'(v);
   endfunction

   assign advance  = !(out_valid && !out_ready);
   assign in_ready = advance || rst;

   // quadrant pre-rotation so the micro-rotations only cover +/-90 degrees
   always_comb begin
      xe    = XW'(x_in);
      ye    = XW'(y_in);
      ze    = ZW'(angle_in);
      pre_x = xe;
      pre_y = ye;
      pre_z = ze;
      if (mode_in == MODE_ROT) begin
         if (ze > Z180)       ze = Z180;
         else if (ze < -Z180) ze = -Z180;
         pre_z = ze;
         if (ze > Z90) begin
            pre_x = -ye;
            pre_y = xe;
            pre_z = ze - Z90;
         end else if (ze < -Z90) begin
            pre_x = ye;
            pre_y = -xe;
            pre_z = ze + Z90;
         end
      end else begin
         if (!xe[XW-1]) begin
            pre_z = '0;
         end else if (!ye[XW-1]) begin
            pre_x = ye;
            pre_y = -xe;
            pre_z = Z90;
         end else begin
            pre_x = -ye;
            pre_y = xe;
            pre_z = -Z90;
         end
      end
   end

   // pre-stage valid bit
   always_ff @(posedge clk) begin
      if (rst)          pre_valid_q <= 1'b0;
      else if (advance) pre_valid_q <= in_valid;
   end

   // pre-stage data registers
   always_ff @(posedge clk) begin
      if (advance) begin
         pre_mode_q <= mode_in;
         pre_x_q    <= pre_x;
         pre_y_q    <= pre_y;
         pre_z_q    <= pre_z;
      end
   end

   assign s_valid[0] = pre_valid_q;
   assign s_mode[0]  = pre_mode_q;
   assign s_x[0]     = pre_x_q;
   assign s_y[0]     = pre_y_q;
   assign s_z[0]     = pre_z_q;

   for (genvar i = 0; i < ITER; i++) begin : g_stage
      cordic_stage #(.DATA_W(DATA_W), .IDX(i)) u_stage (
         .clk       (clk),
         .rst       (rst),
         .advance   (advance),
         .src_valid (s_valid[i]),
         .src_mode  (s_mode[i]),
         .src_x     (s_x[i]),
         .src_y     (s_y[i]),
         .src_z     (s_z[i]),
         .dst_valid (s_valid[i+1]),
         .dst_mode  (s_mode[i+1]),
         .dst_x     (s_x[i+1]),
         .dst_y     (s_y[i+1]),
         .dst_z     (s_z[i+1])
      );
   end

   // optional 1/K gain compensation ahead of saturation
   always_comb begin
      x_prod = PW'(s_x[ITER]) * PW'(GAIN_K);
      y_prod = PW'(s_y[ITER]) * PW'(GAIN_K);
      if (GAIN_COMP != 0) begin
         x_fin = XW'(x_prod >>> 15);
         y_fin = XW'(y_prod >>> 15);
      end else begin
         x_fin = s_x[ITER];
         y_fin = s_y[ITER];
      end
   end

   // output register, the only data stage with a reset value
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         mode_out  <= 1'b0;
         x_out     <= '0;
         y_out     <= '0;
         angle_out <= '0;
      end else if (advance) begin
         out_valid <= s_valid[ITER];
         mode_out  <= s_mode[ITER];
         x_out     <= sat(x_fin);
         y_out     <= sat(y_fin);
         angle_out <= DATA_W'(s_z[ITER]);
      end
   end

endmodule

// File: tb/tb_cordic_unified_pipe.sv
// Bench for cordic_unified_pipe: directed cases plus a randomized mixed-mode
// stream, checked against an ideal trigonometric model.
module tb_cordic_unified_pipe;

   localparam int  DATA_W = 16;
   localparam int  ITER   = 14;
   localparam int  LAT    = ITER + 2;
   localparam real PI     = 3.14159265358979;
   localparam real KC     = 1.6467602581 * 19898.0 / 32768.0;
   // floor-truncating shifts bias the x/y path by a few LSB at small magnitudes
   localparam int  DIR_TOL_XY = 8;
   localparam int  DIR_TOL_A  = 5;
   localparam int  RND_TOL_XY = 10;
   localparam int  RND_TOL_AV = 12;
   localparam int  TOL_RESID  = 3;

   typedef struct {
      bit mode;
      int x;
      int y;
      int a;
      int cyc;
   } rec_t;

   logic                     clk;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic                     mode_in;
   logic signed [DATA_W-1:0] x_in, y_in, angle_in;
   logic                     out_valid;
   logic                     out_ready;
   logic                     mode_out;
   logic signed [DATA_W-1:0] x_out, y_out, angle_out;

   rec_t acc_q[$];
   rec_t got_q[$];
   rec_t stim[40];
   int   cyc;
   int   n_pass;
   int   n_total;
   logic snap_in_ready;
   logic snap_acc;

   cordic_unified_pipe #(.DATA_W(DATA_W), .ITER(ITER), .GAIN_COMP(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode_in   (mode_in),
      .x_in      (x_in),
      .y_in      (y_in),
      .angle_in  (angle_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mode_out  (mode_out),
      .x_out     (x_out),
      .y_out     (y_out),
      .angle_out (angle_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // one clock: record handshakes at the falling edge, return just after the rising edge
   task automatic tick();
      rec_t r;
      @(negedge clk);
      snap_in_ready = in_ready;
      snap_acc      = in_valid && in_ready && !rst;
      if (snap_acc) begin
         r.mode = mode_in; r.x = x_in; r.y = y_in; r.a = angle_in; r.cyc = cyc;
         acc_q.push_back(r);
      end
      if (out_valid && out_ready) begin
         r.mode = mode_out; r.x = x_out; r.y = y_out; r.a = angle_out; r.cyc = cyc;
         got_q.push_back(r);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp, input int tol);
      int d;
      d = obs - exp;
      if (d < 0) d = -d;
      n_total++;
      assert ((d <= tol) === 1'b1) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
   endtask

   function automatic int rnd_sat(input real v);
      if (v > 32767.0)  return 32767;
      if (v < -32768.0) return -32768;
      return $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
   endfunction

   // ideal model: rotate / measure with real trigonometry and the compensated gain
   task automatic check_res(input string tag, input rec_t s, input rec_t r,
                            input int txy, input int ta_vec);
      real rad;
      int  ac;
      chk({tag, ".mode"}, int'(r.mode), int'(s.mode), 0);
      if (s.mode == 1'b0) begin
         ac  = (s.a > 18000) ? 18000 : ((s.a < -18000) ? -18000 : s.a);
         rad = real'(ac) * PI / 18000.0;
         chk({tag, ".x"}, r.x, rnd_sat(KC * (real'(s.x) * $cos(rad) - real'(s.y) * $sin(rad))), txy);
         chk({tag, ".y"}, r.y, rnd_sat(KC * (real'(s.x) * $sin(rad) + real'(s.y) * $cos(rad))), txy);
         chk({tag, ".resid"}, r.a, 0, TOL_RESID);
      end else begin
         chk({tag, ".mag"}, r.x, rnd_sat(KC * $sqrt(real'(s.x) * real'(s.x) + real'(s.y) * real'(s.y))), txy);
         chk({tag, ".yres"}, r.y, 0, txy);
         chk({tag, ".ang"}, r.a, rnd_sat($atan2(real'(s.y), real'(s.x)) * 18000.0 / PI), ta_vec);
      end
   endtask

   // push one sample into an empty pipe and wait for its result
   task automatic send_one(input string tag, input bit m, input int x, input int y, input int a,
                           output rec_t s, output rec_t r);
      int guard;
      acc_q.delete();
      got_q.delete();
      mode_in  = m;
      x_in     = 16'(x);
      y_in     = 16'(y);
      angle_in = 16'(a);
      in_valid = 1'b1;
      guard    = 0;
      do begin
         tick();
         guard++;
      end while (!snap_acc && guard < 20);
      in_valid = 1'b0;
      guard    = 0;
      while (got_q.size() == 0 && guard < 4 * LAT) begin
         tick();
         guard++;
      end
      chk({tag, ".delivered"}, int'(got_q.size() != 0 && acc_q.size() != 0), 1, 0);
      s = '{default: 0};
      r = '{default: 0};
      if (acc_q.size() != 0) s = acc_q.pop_front();
      if (got_q.size() != 0) r = got_q.pop_front();
   endtask

   initial begin
      rec_t s, r;
      int   idx, guard;
      real  rad_m, th;

      cyc       = 0;
      n_pass    = 0;
      n_total   = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      mode_in   = 1'b0;
      x_in      = '0;
      y_in      = '0;
      angle_in  = '0;

      // reset state
      repeat (3) tick();
      chk("rst.out_valid", int'(out_valid), 0, 0);
      chk("rst.in_ready",  int'(in_ready),  1, 0);
      chk("rst.mode_out",  int'(mode_out),  0, 0);
      chk("rst.x_out",     x_out,           0, 0);
      chk("rst.y_out",     y_out,           0, 0);
      chk("rst.angle_out", angle_out,       0, 0);
      rst = 1'b0;
      tick();

      // directed cases
      send_one("rot53", 1'b0, 300, 400, 5300, s, r);
      chk("rot53.latency", r.cyc - s.cyc, LAT, 0);
      chk("rot53.x", r.x, -139, DIR_TOL_XY);
      chk("rot53.y", r.y, 480, DIR_TOL_XY);
      chk("rot53.resid", r.a, 0, TOL_RESID);

      send_one("vec_q1", 1'b1, 300, 400, 0, s, r);
      chk("vec_q1.mode", int'(r.mode), 1, 0);
      chk("vec_q1.mag", r.x, 500, DIR_TOL_XY);
      chk("vec_q1.ang", r.a, 5313, DIR_TOL_A);

      send_one("vec_q3", 1'b1, -300, -400, 0, s, r);
      chk("vec_q3.mag", r.x, 500, DIR_TOL_XY);
      chk("vec_q3.ang", r.a, -12687, DIR_TOL_A);

      send_one("rot180", 1'b0, 100, 0, 18000, s, r);
      chk("rot180.x", r.x, -100, DIR_TOL_XY);
      chk("rot180.y", r.y, 0, DIR_TOL_XY);

      send_one("rot_clamp", 1'b0, 100, 0, 20000, s, r);
      chk("rot_clamp.x", r.x, -100, DIR_TOL_XY);
      chk("rot_clamp.y", r.y, 0, DIR_TOL_XY);

      send_one("vec_zero", 1'b1, 0, 0, 0, s, r);
      chk("vec_zero.x", r.x, 0, 0);
      chk("vec_zero.ang", r.a, 0, 0);

      send_one("vec_sat", 1'b1, 32767, 32767, 0, s, r);
      chk("vec_sat.x", r.x, 32767, 0);
      chk("vec_sat.ang", r.a, 4500, DIR_TOL_A);

      // randomized mixed-mode stream with a 5-cycle output stall
      for (int i = 0; i < 40; i++) begin
         rad_m        = 3000.0 + real'($urandom_range(5000));
         th           = (real'($urandom_range(35999)) - 18000.0) * PI / 18000.0;
         stim[i].mode = 1'($urandom_range(1, 0));
         stim[i].x    = $rtoi(rad_m * $cos(th));
         stim[i].y    = $rtoi(rad_m * $sin(th));
         stim[i].a    = int'($urandom_range(50000)) - 25000;
         stim[i].cyc  = 0;
      end
      acc_q.delete();
      got_q.delete();
      idx   = 0;
      guard = 0;
      while ((idx < 40 || got_q.size() < 40) && guard < 400) begin
         if (idx < 40) begin
            mode_in  = stim[idx].mode;
            x_in     = 16'(stim[idx].x);
            y_in     = 16'(stim[idx].y);
            angle_in = 16'(stim[idx].a);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = !(guard >= 24 && guard < 29);
         tick();
         if (!out_ready) chk("stall.in_ready", int'(snap_in_ready), 0, 0);
         if (snap_acc) idx++;
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (20) tick();
      chk("stream.accepted", acc_q.size(), 40, 0);
      chk("stream.count", got_q.size(), 40, 0);
      for (int i = 0; i < 40; i++) begin
         if (got_q.size() != 0) r = got_q.pop_front();
         else r = '{default: 0};
         check_res($sformatf("stream[%0d]", i), stim[i], r, RND_TOL_XY, RND_TOL_AV);
      end

      // reset with 10 samples in flight
      acc_q.delete();
      got_q.delete();
      for (int i = 0; i < 10; i++) begin
         mode_in  = stim[i].mode;
         x_in     = 16'(stim[i].x);
         y_in     = 16'(stim[i].y);
         angle_in = 16'(stim[i].a);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid.out_valid", int'(out_valid), 0, 0);
      send_one("post_rst", 1'b0, 300, 400, 5300, s, r);
      chk("post_rst.latency", r.cyc - s.cyc, LAT, 0);
      chk("post_rst.x", r.x, -139, DIR_TOL_XY);
      chk("post_rst.y", r.y, 480, DIR_TOL_XY);
      repeat (30) tick();
      chk("post_rst.no_stale", got_q.size(), 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cordic_unified_pipe.md
CORDIC_UNIFIED_PIPE -- requirements
Module: cordic_unified_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the signed width of x/y/angle ports.
REQ-002 SHALL have parameter ITER, default 14 (range 8..16), giving the number of micro-rotation stages.
REQ-003 SHALL have parameter GAIN_COMP, default 1; 1 = outputs scaled by K = 0.60725, 0 = raw CORDIC gain.
REQ-004 SHALL have a single clock; reset is synchronous and active-high.
REQ-005 Ports, in this order:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input sample present.
- in_ready  out  1  pipeline accepts a sample this cycle.
- mode_in  in  1  0 = rotation, 1 = vectoring.
- x_in  in  DATA_W  signed x.
- y_in  in  DATA_W  signed y.
- angle_in  in  DATA_W  signed angle in hundredths of a degree (rotation mode only).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- mode_out  out  1  mode tag of the result.
- x_out  out  DATA_W  signed x result.
- y_out  out  DATA_W  signed y result.
- angle_out  out  DATA_W  signed angle result in hundredths of a degree.

Function
REQ-006 Pipeline: 1 pre-rotation stage, ITER iteration stages and 1 output stage; latency ITER+2 accepted cycles (16 at default); throughput 1 sample per cycle.
REQ-007 Global stall: advance = !(out_valid && !out_ready); every stage, its valid bit and its mode tag hold when advance = 0.
REQ-008 in_ready = advance; a sample is accepted only when in_valid && in_ready.
REQ-009 Results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-010 Rotation pre-stage: clamp angle_in to ±18000.
- If z > 9000: (x,y,z) = (-y, x, z-9000).
- If z < -9000: (x,y,z) = (y, -x, z+9000).
- Otherwise pass through.
REQ-011 Vectoring pre-stage:
- If x >= 0: z = 0, pass through.
- If x < 0 and y >= 0: (x,y,z) = (y, -x, 9000).
- If x < 0 and y < 0: (x,y,z) = (-y, x, -9000).
REQ-012 Iteration i (0..ITER-1):
- Direction d = sign(z) in rotation mode, -sign(y) in vectoring mode; zero counts as positive.
- x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*ATAN[i].
REQ-013 Internal x/y width SHALL be DATA_W+2; z width DATA_W+1; shifts arithmetic.
REQ-014 Output stage:
- If GAIN_COMP = 1, x and y are multiplied by 19898 (K in Q1.15) and shifted >>>15.
- x_out and y_out saturate to the DATA_W signed range; angle_out = final z.
REQ-015 Rotation mode: x_out/y_out = rotated vector, angle_out = residual (|residual| <= 2).
REQ-016 Vectoring mode: x_out = magnitude, y_out = residual (~0), angle_out = atan2(y_in, x_in) within ±18000.
REQ-017 Input x = y = 0 in vectoring mode SHALL yield x_out = 0 and angle_out = 0.

Reset
REQ-018 While rst = 1:
- All valid bits clear; out_valid = 0.
- x_out, y_out, angle_out and mode_out = 0.
- in_ready = 1.
REQ-019 Reset mid-stream discards all in-flight samples; the first sample accepted after reset emerges exactly ITER+2 advancing cycles later.
REQ-020 Data registers other than the outputs need no reset; valid bits gate them.

Structure
REQ-021 Package cordic_pkg SHALL hold:
- ATAN table in hundredths of a degree: 4500, 2657, 1404, 713, 358, 179, 90, 45, 22, 11, 6, 3, 1, 1, 0, 0.
- Gain constant 19898, the angle limits 9000 and 18000, and the mode encodings.
REQ-022 One sub-module, cordic_stage, parametrised by iteration index, SHALL implement REQ-012 plus its valid/mode register; it is instantiated ITER times via generate.

Verification (GAIN_COMP = 1, tolerance ±3 LSB)
REQ-023 Rotation (300, 400, 5300) -> x_out ≈ -139, y_out ≈ 480, out_valid exactly 16 cycles after acceptance.
REQ-024 Vectoring (300, 400) -> x_out ≈ 500, angle_out ≈ 5313; vectoring (-300, -400) -> x_out ≈ 500, angle_out ≈ -12687.
REQ-025 Rotation (100, 0, 18000) -> (-100, 0); rotation (100, 0, 20000) clamped -> (-100, 0).
REQ-026 Stream 40 mixed-mode samples with out_ready low for 5 cycles mid-stream -> in_ready low during the stall, all 40 results in order, matching a model.
REQ-027 Assert rst for 1 cycle with 10 samples in flight -> out_valid = 0 the next cycle, no stale results emerge, and a new sample emerges 16 cycles after acceptance.
REQ-028 Vectoring (32767, 32767) -> x_out saturates to 32767 and angle_out ≈ 4500.
